// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch front end.
// The fetch queue stores one PC/instruction pair per entry.
package fetch_pkg;

  localparam int          XLEN      = 32;
  localparam logic [31:0] RESET_PC  = 32'h0000_0000;
  localparam logic [31:0] INSTR_NOP = 32'h0000_0013;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Instruction-memory read port plus the decode-facing valid/ready handshake.
// The fetch unit uses the master side; memory and decode use the slave side.
interface instr_fetch_unit_if #(
  parameter int XLEN       = 32,
  parameter int IMEM_DEPTH = 32
);
  localparam int AW = $clog2(IMEM_DEPTH);

  logic [AW-1:0]   imem_addr;
  logic [XLEN-1:0] imem_rdata;
  logic            instr_valid;
  logic            instr_ready;
  logic [XLEN-1:0] instr;
  logic [XLEN-1:0] instr_pc;

  modport master (
    output imem_addr, instr_valid, instr, instr_pc,
    input  imem_rdata, instr_ready
  );

  modport slave (
    input  imem_addr, instr_valid, instr, instr_pc,
    output imem_rdata, instr_ready
  );
endinterface

// File: rtl/fetch_queue.sv
// Synchronous FIFO of fetched PC/instruction pairs.
// Flush beats push and pop; a full queue still accepts a push when popped.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int QDEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic                   pop,
  input  logic                   flush,
  input  fetch_entry_t           wr_entry,
  output fetch_entry_t           rd_entry,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(QDEPTH):0] count
);

  localparam int PW = $clog2(QDEPTH);
  localparam int CW = PW + 1;

  fetch_entry_t  mem [QDEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full     = (count == CW'(QDEPTH));
  assign empty    = (count == '0);
  assign do_pop   = pop & ~empty;
  assign do_push  = push & (~full | do_pop);
  assign rd_entry = mem[rd_ptr];

  // Storage is cleared on reset so the head reads as zero until the first push.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < QDEPTH; i++) mem[i] <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= wr_entry;
        wr_ptr      <= wr_ptr + PW'(1);
      end
      if (do_pop) rd_ptr <= rd_ptr + PW'(1);
      if (do_push && !do_pop)      count <= count + CW'(1);
      else if (!do_push && do_pop) count <= count - CW'(1);
    end
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: PC register, branch redirect and stall handling, and the
// instruction-memory address slice feeding a small decoupling queue.
module instr_fetch_unit
  import fetch_pkg::*;
#(
  parameter int              XLEN       = fetch_pkg::XLEN,
  parameter int              IMEM_DEPTH = 32,
  parameter int              QDEPTH     = 4,
  parameter logic [XLEN-1:0] RESET_PC   = fetch_pkg::RESET_PC
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    pcsrc,
  input  logic [XLEN-1:0]         branch_target,
  input  logic                    stall,
  instr_fetch_unit_if.master      bus,
  output logic [$clog2(QDEPTH):0] q_count
);

  localparam int AW = $clog2(IMEM_DEPTH);

  logic [XLEN-1:0] pc;
  logic            q_full;
  logic            q_empty;
  logic            pop;
  logic            fetch_en;
  fetch_entry_t    wr_entry;
  fetch_entry_t    rd_entry;

  assign bus.imem_addr   = pc[AW+1:2];
  // A pending redirect hides the head so nothing stale reaches decode.
  assign bus.instr_valid = ~q_empty & ~pcsrc;
  assign bus.instr       = rd_entry.instr;
  assign bus.instr_pc    = rd_entry.pc;

  assign pop      = bus.instr_valid & bus.instr_ready;
  assign fetch_en = ~rst & ~stall & ~pcsrc & (~q_full | pop);
  assign wr_entry = '{pc: pc, instr: bus.imem_rdata};

  always_ff @(posedge clk) begin
    if (rst)           pc <= RESET_PC;
    else if (pcsrc)    pc <= branch_target & ~XLEN'(3);
    else if (fetch_en) pc <= pc + XLEN'(4);
  end

  fetch_queue #(
    .QDEPTH (QDEPTH)
  ) u_queue (
    .clk      (clk),
    .rst      (rst),
    .push     (fetch_en),
    .pop      (pop),
    .flush    (pcsrc),
    .wr_entry (wr_entry),
    .rd_entry (rd_entry),
    .full     (q_full),
    .empty    (q_empty),
    .count    (q_count)
  );

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: one DUT at RESET_PC 0 and one at 0x7C
// for the address wrap case, both driven by the same stimulus.
module tb_instr_fetch_unit;

  logic        clk;
  logic        rst;
  logic        pcsrc;
  logic [31:0] branch_target;
  logic        stall;
  logic        ready;
  logic [2:0]  q_count0;
  logic [2:0]  q_count1;
  logic [31:0] imem [32];
  int          checkCount;
  int          passCount;

  instr_fetch_unit_if #(.XLEN(32), .IMEM_DEPTH(32)) bus0 ();
  instr_fetch_unit_if #(.XLEN(32), .IMEM_DEPTH(32)) bus1 ();

  assign bus0.imem_rdata  = imem[bus0.imem_addr];
  assign bus0.instr_ready = ready;
  assign bus1.imem_rdata  = imem[bus1.imem_addr];
  assign bus1.instr_ready = ready;

  instr_fetch_unit #(
    .XLEN(32), .IMEM_DEPTH(32), .QDEPTH(4), .RESET_PC(32'h0000_0000)
  ) dut0 (
    .clk           (clk),
    .rst           (rst),
    .pcsrc         (pcsrc),
    .branch_target (branch_target),
    .stall         (stall),
    .bus           (bus0.master),
    .q_count       (q_count0)
  );

  instr_fetch_unit #(
    .XLEN(32), .IMEM_DEPTH(32), .QDEPTH(4), .RESET_PC(32'h0000_007C)
  ) dut1 (
    .clk           (clk),
    .rst           (rst),
    .pcsrc         (pcsrc),
    .branch_target (branch_target),
    .stall         (stall),
    .bus           (bus1.master),
    .q_count       (q_count1)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic applyStimulus(input logic r, input logic p, input logic [31:0] t,
                               input logic s, input logic rdy);
    rst           = r;
    pcsrc         = p;
    branch_target = t;
    stall         = s;
    ready         = rdy;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    assert (observed === expected) passCount++;
    else $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
  endtask

  task automatic doReset();
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
    tick();
    tick();
  endtask

  initial begin
    checkCount = 0;
    passCount  = 0;
    for (int i = 0; i < 32; i++) imem[i] = 32'h1000_0000 + i;

    // Reset state and free-running fetch
    doReset();
    checkOutput("rst_count", 32'(q_count0), 32'd0);
    checkOutput("rst_valid", 32'(bus0.instr_valid), 32'd0);
    checkOutput("rst_instr", bus0.instr, 32'd0);
    checkOutput("rst_pc", bus0.instr_pc, 32'd0);
    checkOutput("rst_addr", 32'(bus0.imem_addr), 32'd0);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
    checkOutput("run_valid0", 32'(bus0.instr_valid), 32'd0);
    for (int k = 0; k < 3; k++) begin
      tick();
      checkOutput("run_valid", 32'(bus0.instr_valid), 32'd1);
      checkOutput("run_pc", bus0.instr_pc, 32'(4 * k));
      checkOutput("run_instr", bus0.instr, 32'h1000_0000 + 32'(k));
    end

    // Backpressure fills the queue and holds the PC at 16
    doReset();
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    for (int k = 0; k < 8; k++) tick();
    checkOutput("bp_count", 32'(q_count0), 32'd4);
    checkOutput("bp_addr", 32'(bus0.imem_addr), 32'd4);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
    for (int k = 0; k < 5; k++) begin
      checkOutput("bp_pc", bus0.instr_pc, 32'(4 * k));
      checkOutput("bp_instr", bus0.instr, 32'h1000_0000 + 32'(k));
      tick();
    end

    // Redirect with three entries queued
    doReset();
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) tick();
    checkOutput("br_pre_count", 32'(q_count0), 32'd3);
    applyStimulus(1'b0, 1'b1, 32'h0000_0042, 1'b0, 1'b1);
    checkOutput("br_valid", 32'(bus0.instr_valid), 32'd0);
    tick();
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
    checkOutput("br_count", 32'(q_count0), 32'd0);
    checkOutput("br_addr", 32'(bus0.imem_addr), 32'd16);
    tick();
    checkOutput("br_new_valid", 32'(bus0.instr_valid), 32'd1);
    checkOutput("br_new_pc", bus0.instr_pc, 32'h0000_0040);
    checkOutput("br_new_instr", bus0.instr, 32'h1000_0010);

    // Stall drains the queue with the PC frozen, then full push/pop
    doReset();
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    for (int k = 0; k < 5; k++) tick();
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
    for (int k = 0; k < 4; k++) begin
      checkOutput("st_pc", bus0.instr_pc, 32'(4 * k));
      tick();
    end
    checkOutput("st_count", 32'(q_count0), 32'd0);
    checkOutput("st_valid", 32'(bus0.instr_valid), 32'd0);
    checkOutput("st_addr", 32'(bus0.imem_addr), 32'd4);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    for (int k = 0; k < 4; k++) tick();
    checkOutput("full_count", 32'(q_count0), 32'd4);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
    for (int k = 0; k < 3; k++) begin
      tick();
      checkOutput("full_pp_count", 32'(q_count0), 32'd4);
      checkOutput("full_pp_pc", bus0.instr_pc, 32'(20 + 4 * k));
    end

    // Address wrap on the 0x7C instance
    doReset();
    checkOutput("wrap_addr0", 32'(bus1.imem_addr), 32'd31);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
    tick();
    checkOutput("wrap_pc0", bus1.instr_pc, 32'h0000_007C);
    checkOutput("wrap_instr0", bus1.instr, 32'h1000_001F);
    checkOutput("wrap_addr1", 32'(bus1.imem_addr), 32'd0);
    tick();
    checkOutput("wrap_pc1", bus1.instr_pc, 32'h0000_0080);
    checkOutput("wrap_instr1", bus1.instr, 32'h1000_0000);

    // Reset mid-operation overrides a simultaneous redirect
    doReset();
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) tick();
    applyStimulus(1'b1, 1'b1, 32'h0000_0042, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
    checkOutput("mid_count", 32'(q_count0), 32'd0);
    checkOutput("mid_valid", 32'(bus0.instr_valid), 32'd0);
    checkOutput("mid_addr", 32'(bus0.imem_addr), 32'd0);
    tick();
    checkOutput("mid_pc", bus0.instr_pc, 32'h0000_0000);
    checkOutput("mid_instr", bus0.instr, 32'h1000_0000);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
